// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - RV32I multicycle control: opcodes, funct fields, FSM states, ALU codes
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EX  = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational opcode/funct3/funct7 to ALU operation and illegal flag
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o
);

    logic [3:0] op;
    logic       bad;
    logic       f7_base;
    logic       f7_alt;

    assign f7_base = (funct7_i == F7_BASE);
    assign f7_alt  = (funct7_i == F7_ALT);

    always_comb begin
        op  = ALU_ADD;
        bad = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct3_i)
                    F3_ADD_SUB: begin
                        op  = f7_alt ? ALU_SUB : ALU_ADD;
                        bad = !(f7_base || f7_alt);
                    end
                    F3_SLL: begin op = ALU_SLL; bad = !f7_base; end
                    F3_SLT: begin op = ALU_SLT; bad = !f7_base; end
                    F3_XOR: begin op = ALU_XOR; bad = !f7_base; end
                    F3_SRL_SRA: begin
                        op  = f7_alt ? ALU_SRA : ALU_SRL;
                        bad = !(f7_base || f7_alt);
                    end
                    F3_OR:  begin op = ALU_OR;  bad = !f7_base; end
                    F3_AND: begin op = ALU_AND; bad = !f7_base; end
                    default: bad = 1'b1;
                endcase
            end
            OP_IALU: begin
                // funct7 is immediate data except for shifts, where it selects SRA
                case (funct3_i)
                    F3_ADD_SUB: op = ALU_ADD;
                    F3_SLT:     op = ALU_SLT;
                    F3_XOR:     op = ALU_XOR;
                    F3_OR:      op = ALU_OR;
                    F3_AND:     op = ALU_AND;
                    F3_SLL: begin op = ALU_SLL; bad = !f7_base; end
                    F3_SRL_SRA: begin
                        op  = f7_alt ? ALU_SRA : ALU_SRL;
                        bad = !(f7_base || f7_alt);
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                op  = ALU_ADD;
                bad = (funct3_i != F3_LW);
            end
            OP_STORE: begin
                op  = ALU_ADD;
                bad = (funct3_i != F3_SW);
            end
            OP_BRANCH: begin
                op  = ALU_SUB;
                bad = (funct3_i != F3_BEQ);
            end
            default: bad = 1'b1;
        endcase
    end

    assign alu_ctrl_o = bad ? ALU_AND : op;
    assign illegal_o  = bad;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multicycle FSM and control word; CTRL_MEM_WAIT_EN stretches MEM on dReady
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [2:0] INITIAL_STATE = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        dReady,
    output logic        PCSrc,
    output logic        loadPC,
    output logic        ALUSrc,
    output logic [3:0]  ALUCtrl,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t     state_q;
    state_t     state_d;
    logic [6:0] opcode;
    logic [3:0] dec_alu;
    logic       dec_illegal;
    logic       is_r;
    logic       is_i;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       uses_imm;
    logic       reg_wr;
    logic       mem_done;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];

    alu_decoder u_alu_decoder (
        .opcode_i   (opcode),
        .funct3_i   (instr[14:12]),
        .funct7_i   (instr[31:25]),
        .alu_ctrl_o (dec_alu),
        .illegal_o  (dec_illegal)
    );

    // Register operand/destination fields belong to the datapath only
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // Class flags are qualified with legality so illegal words never strobe
    assign is_r     = (opcode == OP_RTYPE)  && !dec_illegal;
    assign is_i     = (opcode == OP_IALU)   && !dec_illegal;
    assign is_lw    = (opcode == OP_LOAD)   && !dec_illegal;
    assign is_sw    = (opcode == OP_STORE)  && !dec_illegal;
    assign is_beq   = (opcode == OP_BRANCH) && !dec_illegal;
    assign uses_imm = is_i || is_lw || is_sw;
    assign reg_wr   = is_r || is_i || is_lw;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_done = !(is_lw || is_sw) || dReady;
`else
    logic unused_dready;
    assign unused_dready = dReady;
    assign mem_done      = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_t'(INITIAL_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = S_IF;
        PCSrc    = 1'b0;
        loadPC   = 1'b0;
        ALUSrc   = 1'b0;
        ALUCtrl  = ALU_AND;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        illegal  = 1'b0;

        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID:    state_d = S_EX;
            S_EX:    state_d = S_MEM;
            S_MEM:   state_d = mem_done ? S_WB : S_MEM;
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase

        // Reset gates every strobe in the same cycle, so no partial write escapes
        if (!rst) begin
            if (state_q inside {S_ID, S_EX, S_MEM, S_WB}) begin
                ALUSrc  = uses_imm;
                ALUCtrl = dec_alu;
            end
            if (state_q == S_MEM) begin
                MemRead  = is_lw;
                MemWrite = is_sw;
            end
            if (state_q == S_WB) begin
                loadPC   = 1'b1;
                PCSrc    = is_beq && Zero;
                RegWrite = reg_wr;
                MemToReg = is_lw;
                illegal  = dec_illegal;
            end
        end
    end

    assign state = state_q;

endmodule
